sev_seg_scan_ctrl: RTL and testbench

SEV_SEG_SCAN_CTRL -- requirements
Module: sev_seg_scan_ctrl

---
 rtl/sev_seg_pkg.sv | 19 +
 rtl/hex_to_sev_seg.sv | 33 +++
 rtl/sev_seg_scan_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sev_seg_scan_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sev_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sev_seg_pkg;

  // Scan controller states: dark, driving one digit, dead time between digits.
  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } scan_state_t;

  // Active-low segment pattern with every segment dark.
  localparam logic [0:6] SEG_BLANK = 7'h7F;

  // Default parameter values for the controller.
  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_DIGIT_CYCLES = 50000;
  localparam int DEF_GAP_CYCLES   = 500;

endpackage

// File: rtl/hex_to_sev_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Output is [0:6] with segment a at index 0 and g at index 6, so each
// literal below reads "abcdefg" left to right (0 = segment lit).
module hex_to_sev_seg (
  input  logic [3:0] nibble,
  output logic [0:6] seg_n
);

  // Hex glyph lookup
  always_comb begin
    seg_n = 7'b1111111;
    case (nibble)
      4'h0: seg_n = 7'b0000001;
      4'h1: seg_n = 7'b1001111;
      4'h2: seg_n = 7'b0010010;
      4'h3: seg_n = 7'b0000110;
      4'h4: seg_n = 7'b1001100;
      4'h5: seg_n = 7'b0100100;
      4'h6: seg_n = 7'b0100000;
      4'h7: seg_n = 7'b0001111;
      4'h8: seg_n = 7'b0000000;
      4'h9: seg_n = 7'b0000100;
      4'hA: seg_n = 7'b0001000;
      4'hB: seg_n = 7'b1100000;
      4'hC: seg_n = 7'b0110001;
      4'hD: seg_n = 7'b1000010;
      4'hE: seg_n = 7'b0110000;
      4'hF: seg_n = 7'b0111000;
      default: seg_n = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/sev_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller. A value written through the
// valid/ready port waits in a shadow register and is promoted to the active
// register only at a frame boundary (or when the display starts), so a
// frame never mixes old and new digits. Pins are driven from registers that
// are loaded with the values belonging to the state/digit being entered.
module sev_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = sev_seg_pkg::DEF_NUM_DIGITS,
  parameter int DIGIT_CYCLES = sev_seg_pkg::DEF_DIGIT_CYCLES,
  parameter int GAP_CYCLES   = sev_seg_pkg::DEF_GAP_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    disp_en,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic [NUM_DIGITS-1:0]   wr_blank,
  input  logic                    wr_lz_en,
  output logic [0:6]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n
);
  import sev_seg_pkg::*;

  // One counter serves both timed states, so it is sized for the longer one.
  localparam int MAX_CYCLES = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic load_en;

  logic                    pending;
  logic [4*NUM_DIGITS-1:0] shadow_data, active_data, view_data;
  logic [NUM_DIGITS-1:0]   shadow_blank, active_blank, view_blank;
  logic                    shadow_lz, active_lz, view_lz;
  // Set once something has been promoted to active since reset; lets a
  // re-enable resume the current value while keeping a fresh reset dark.
  logic                    active_valid;

  logic [NUM_DIGITS:0]   upper_zero;
  logic [NUM_DIGITS-1:0] digit_blank;
  logic [3:0]            nibble;
  logic [0:6]            dec_seg;
  logic [0:6]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign wr_ready = !pending;

  // State, cycle counter and digit index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_OFF;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  // Next-state logic: digit timing, gap timing, wrap and frame-boundary load
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    load_en    = 1'b0;
    if (!disp_en) begin
      state_next = S_OFF;
      cnt_next   = '0;
      idx_next   = '0;
    end else begin
      case (state)
        S_OFF: begin
          if (pending || active_valid) begin
            state_next = S_DRIVE;
            cnt_next   = '0;
            idx_next   = '0;
            load_en    = pending;
          end
        end
        S_DRIVE: begin
          if (cnt == DIGIT_LAST) begin
            state_next = S_GAP;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            state_next = S_DRIVE;
            cnt_next   = '0;
            if (idx == IDX_LAST) begin
              idx_next = '0;
              load_en  = pending;
            end else begin
              idx_next = idx + 1'b1;
            end
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        default: begin
          state_next = S_OFF;
          cnt_next   = '0;
          idx_next   = '0;
        end
      endcase
    end
  end

  // Write handshake into shadow, promotion of shadow into active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= 1'b0;
      active_valid <= 1'b0;
      shadow_data  <= '0;
      shadow_blank <= '0;
      shadow_lz    <= 1'b0;
      active_data  <= '0;
      active_blank <= '0;
      active_lz    <= 1'b0;
    end else if (load_en) begin
      pending      <= 1'b0;
      active_valid <= 1'b1;
      active_data  <= shadow_data;
      active_blank <= shadow_blank;
      active_lz    <= shadow_lz;
    end else if (wr_valid && !pending) begin
      pending      <= 1'b1;
      shadow_data  <= wr_data;
      shadow_blank <= wr_blank;
      shadow_lz    <= wr_lz_en;
    end
  end

  // The value that will be active after this edge feeds the output decode,
  // so the pins are correct on the very edge that enters a digit.
  assign view_data  = load_en ? shadow_data  : active_data;
  assign view_blank = load_en ? shadow_blank : active_blank;
  assign view_lz    = load_en ? shadow_lz    : active_lz;

  // upper_zero[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
  assign upper_zero[NUM_DIGITS] = 1'b1;
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
    assign upper_zero[gi] = (view_data[4*gi +: 4] == 4'h0) && upper_zero[gi+1];
    if (gi == 0) begin : g_rightmost
      assign digit_blank[gi] = view_blank[gi];
    end else begin : g_upper
      assign digit_blank[gi] = view_blank[gi] || (view_lz && upper_zero[gi]);
    end
  end

  assign nibble = view_data[{idx_next, 2'b00} +: 4];

  hex_to_sev_seg u_dec (
    .nibble (nibble),
    .seg_n  (dec_seg)
  );

  // Output decode for the state/digit being entered
  always_comb begin
    an_next  = '1;
    seg_next = SEG_BLANK;
    if (state_next == S_DRIVE) begin
      an_next[idx_next] = 1'b0;
      seg_next          = digit_blank[idx_next] ? SEG_BLANK : dec_seg;
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n  <= '1;
      seg_n <= SEG_BLANK;
    end else begin
      an_n  <= an_next;
      seg_n <= seg_next;
    end
  end

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Scoreboard bench for the seven-segment scan controller.
// Expected pin values are queued when stimulus is applied and popped one
// per clock just after each rising edge.
module tb_sev_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int D     = 4;
  localparam int G     = 2;
  localparam int FRAME = N * (D + G);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_en = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_lz_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic [3:0]  wr_blank = '0;
  logic        wr_ready;
  logic [0:6]  seg_n;
  logic [3:0]  an_n;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [0:6] seg;
  } exp_t;

  exp_t sb[$];

  logic [15:0] last_d;
  logic [3:0]  last_b;
  logic        last_lz;

  always #5 clk = ~clk;

  sev_seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .DIGIT_CYCLES (D),
    .GAP_CYCLES   (G)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .disp_en  (disp_en),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .wr_blank (wr_blank),
    .wr_lz_en (wr_lz_en),
    .seg_n    (seg_n),
    .an_n     (an_n)
  );

  // Reference glyphs, written as "abcdefg", 0 = lit.
  function automatic logic [0:6] ref_seg(input logic [3:0] v);
    logic [0:6] s;
    case (v)
      4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;  default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  function automatic logic ref_blank(input logic [15:0] d, input logic [3:0] b,
                                     input logic lz, input int i);
    logic zeros;
    zeros = 1'b1;
    if (b[i]) return 1'b1;
    if (!lz || i == 0) return 1'b0;
    for (int j = i; j < N; j++) if (d[4*j +: 4] != 4'h0) zeros = 1'b0;
    return zeros;
  endfunction

  task automatic push_off(input int n);
    exp_t e;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    for (int k = 0; k < n; k++) sb.push_back(e);
  endtask

  task automatic push_digit(input logic [15:0] d, input logic [3:0] b, input logic lz,
                            input int i, input int n);
    exp_t e;
    e.an    = 4'hF;
    e.an[i] = 1'b0;
    e.seg   = ref_blank(d, b, lz, i) ? 7'h7F : ref_seg(d[4*i +: 4]);
    for (int k = 0; k < n; k++) sb.push_back(e);
  endtask

  task automatic push_frame(input logic [15:0] d, input logic [3:0] b, input logic lz);
    for (int i = 0; i < N; i++) begin
      push_digit(d, b, lz, i, D);
      push_off(G);
    end
  endtask

  // Advance n clocks; after each rising edge pop and compare one expectation.
  task automatic run(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard_underrun: an_n=%b seg_n=%b with nothing expected", an_n, seg_n);
      end else begin
        e = sb.pop_front();
        vectors += 2;
        if (an_n !== e.an) begin
          miscompares++;
          $display("FAIL an_n: got %b expected %b (t=%0t)", an_n, e.an, $time);
        end
        if (seg_n !== e.seg) begin
          miscompares++;
          $display("FAIL seg_n: got %b expected %b (t=%0t)", seg_n, e.seg, $time);
        end
      end
      @(negedge clk);
    end
  endtask

  // Offer one value for one clock; caller has queued that clock's pins.
  task automatic write_one(input logic [15:0] d, input logic [3:0] b, input logic lz);
    $display("write data=%h blank=%b lz=%b ready=%b", d, b, lz, wr_ready);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_blank = b;
    wr_lz_en = lz;
    run(1);
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    disp_en = 1'b0;
    repeat (2) @(negedge clk);
    vectors += 3;
    if (an_n !== 4'hF) begin miscompares++; $display("FAIL reset_an: got %b expected 1111", an_n); end
    if (seg_n !== 7'h7F) begin miscompares++; $display("FAIL reset_seg: got %b expected 1111111", seg_n); end
    if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", wr_ready); end
    rst_n   = 1'b1;
    disp_en = 1'b1;
    push_off(4);
    run(4);
  endtask

  task automatic test_basic();
    vectors++;
    if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready_idle: got %b expected 1", wr_ready); end
    push_off(1);
    write_one(16'h12AF, 4'b0000, 1'b0);
    vectors++;
    if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL basic_ready_pending: got %b expected 0", wr_ready); end
    push_frame(16'h12AF, 4'b0000, 1'b0);
    run(FRAME);
    vectors++;
    if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL basic_ready_after_load: got %b expected 1", wr_ready); end
  endtask

  task automatic test_back_to_back();
    push_digit(16'h12AF, 4'b0, 1'b0, 0, D);
    push_off(G);
    push_digit(16'h12AF, 4'b0, 1'b0, 1, 1);
    run(D + G + 1);
    wr_valid = 1'b1;
    wr_data  = 16'h1111;
    wr_blank = 4'b0;
    wr_lz_en = 1'b0;
    $display("write data=1111 during digit 1");
    push_digit(16'h12AF, 4'b0, 1'b0, 1, 1);
    run(1);
    vectors++;
    if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_after_accept: got %b expected 0", wr_ready); end
    wr_data = 16'h5555;
    $display("write data=5555 offered while busy");
    push_digit(16'h12AF, 4'b0, 1'b0, 1, D - 2);
    push_off(G);
    for (int i = 2; i < N; i++) begin
      push_digit(16'h12AF, 4'b0, 1'b0, i, D);
      push_off(G);
    end
    run(D - 2 + G + 2 * (D + G));
    vectors++;
    if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_held: got %b expected 0", wr_ready); end
    push_digit(16'h1111, 4'b0, 1'b0, 0, 1);
    run(1);
    vectors++;
    if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_at_boundary: got %b expected 1", wr_ready); end
    push_digit(16'h1111, 4'b0, 1'b0, 0, 1);
    run(1);
    wr_valid = 1'b0;
    vectors++;
    if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_held_write_taken: got %b expected 0", wr_ready); end
    push_digit(16'h1111, 4'b0, 1'b0, 0, D - 2);
    push_off(G);
    for (int i = 1; i < N; i++) begin
      push_digit(16'h1111, 4'b0, 1'b0, i, D);
      push_off(G);
    end
    run(D - 2 + G + 3 * (D + G));
    push_digit(16'h5555, 4'b0, 1'b0, 0, D);
    run(D);
    vectors++;
    if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_final: got %b expected 1", wr_ready); end
  endtask

  task automatic test_disable();
    push_off(G);
    push_digit(16'h5555, 4'b0, 1'b0, 1, 2);
    run(G + 2);
    disp_en = 1'b0;
    push_off(4);
    run(4);
    disp_en = 1'b1;
    push_digit(16'h5555, 4'b0, 1'b0, 0, D);
    push_off(G);
    push_digit(16'h5555, 4'b0, 1'b0, 1, 1);
    run(D + G + 1);
    disp_en = 1'b0;
    push_off(1);
    run(1);
  endtask

  task automatic show_value(input logic [15:0] d, input logic [3:0] b, input logic lz);
    disp_en = 1'b0;
    push_off(1);
    run(1);
    push_off(1);
    write_one(d, b, lz);
    disp_en = 1'b1;
    push_frame(d, b, lz);
    run(FRAME);
    last_d  = d;
    last_b  = b;
    last_lz = lz;
  endtask

  task automatic test_lz();
    show_value(16'h0040, 4'b0000, 1'b1);
    show_value(16'h0000, 4'b0000, 1'b1);
    show_value(16'h0000, 4'b0001, 1'b1);
    show_value(16'h0F00, 4'b0100, 1'b1);
    show_value(16'h12AF, 4'b0000, 1'b1);
  endtask

  task automatic test_random();
    logic [15:0] d;
    logic [3:0]  b;
    logic        lz;
    for (int k = 0; k < 5; k++) begin
      d  = 16'($urandom) >> (4 * $urandom_range(0, 3));
      b  = 4'($urandom_range(0, 15)) & {4{($urandom_range(0, 1) == 1)}};
      lz = 1'($urandom_range(0, 1));
      show_value(d, b, lz);
    end
  endtask

  task automatic test_reset_mid_gap();
    push_digit(last_d, last_b, last_lz, 0, 1);
    run(1);
    wr_valid = 1'b1;
    wr_data  = 16'hBEEF;
    wr_blank = 4'b0;
    wr_lz_en = 1'b0;
    push_digit(last_d, last_b, last_lz, 0, 1);
    run(1);
    wr_valid = 1'b0;
    vectors++;
    if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL midgap_pending: got %b expected 0", wr_ready); end
    push_digit(last_d, last_b, last_lz, 0, D - 2);
    push_off(1);
    run(D - 2 + 1);
    #2;
    rst_n = 1'b0;
    #1;
    vectors += 3;
    if (an_n !== 4'hF) begin miscompares++; $display("FAIL midgap_reset_an: got %b expected 1111", an_n); end
    if (seg_n !== 7'h7F) begin miscompares++; $display("FAIL midgap_reset_seg: got %b expected 1111111", seg_n); end
    if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL midgap_reset_ready: got %b expected 1", wr_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    push_off(5);
    run(5);
    push_off(1);
    write_one(16'h0007, 4'b0000, 1'b1);
    push_digit(16'h0007, 4'b0000, 1'b1, 0, 1);
    push_digit(16'h0007, 4'b0000, 1'b1, 0, 1);
    run(2);
    disp_en = 1'b0;
    push_off(1);
    run(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_disable();
    test_lz();
    test_random();
    test_reset_mid_gap();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
